// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2 stride-2 signed max-pool stage with line buffer
module maxpool2x2_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 416,
  parameter int IMG_H  = 416
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int LB_N = IMG_W / 2;
  localparam int LW   = (LB_N > 1) ? $clog2(LB_N) : 1;

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  // Partial maxima of the even row, one per pooled column
  logic [DATA_W-1:0] linebuf [LB_N];

  logic              accept;
  logic [CW-1:0]     col_e;
  logic [RW-1:0]     row_e;
  logic [LW-1:0]     lb_idx;
  logic [DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0] max_hold_in;
  logic [DATA_W-1:0] max_in_lb;
  logic              frame_end;

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  // The output register may only be replaced when it is empty or being drained
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame beat is always pixel (0,0), whatever the counters say
  assign col_e = in_sof ? '0 : col_q;
  assign row_e = in_sof ? '0 : row_q;

  assign lb_idx      = LW'(col_e >> 1);
  assign lb_rd       = linebuf[lb_idx];
  assign max_hold_in = smax(hold_q, in_data);
  assign max_in_lb   = smax(in_data, lb_rd);
  assign frame_end   = (row_e == RW'(IMG_H - 1)) && (col_e == CW'(IMG_W - 1));

  // Next-state: raster counters, horizontal pair hold, and the output stage
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (col_e == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_e == RW'(IMG_H - 1)) ? '0 : row_e + RW'(1);
      end else begin
        col_d = col_e + CW'(1);
        row_d = row_e;
      end

      case ({row_e[0], col_e[0]})
        2'b00: hold_d = in_data;
        2'b10: hold_d = max_in_lb;
        2'b11: begin
          out_data_d  = max_hold_in;
          out_valid_d = 1'b1;
          out_last_d  = frame_end;
        end
        default: ;
      endcase
    end
  end

  // State registers; a reset mid-frame drops any pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer needs no reset: each entry is written on an even row before the odd row reads it
  always_ff @(posedge clk) begin
    if (accept && !row_e[0] && col_e[0]) begin
      linebuf[lb_idx] <= max_hold_in;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - checks the 2x2 max-pool stream against a frame-level model
`timescale 1ns/1ps
module tb_maxpool2x2_stream;

  localparam int DW   = 16;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPX  = W * H;
  localparam int NOUT = (W / 2) * (H / 2);

  typedef logic [DW-1:0] frame_t [NPX];
  typedef logic [DW-1:0] lit_t [NOUT];

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;

  logic [DW:0]   exp_q [$];
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always #5 clk = ~clk;

  maxpool2x2_stream #(
    .DATA_W(DW),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    total++;
    bad++;
    $display("FAIL %s: %s at %0t", name, msg, $time);
  endtask

  // Max of the 2x2 window at pooled coordinate (pr, pc), by plain signed arithmetic
  function automatic logic [DW-1:0] pool_at(input frame_t f, input int pr, input int pc);
    int m;
    int v;
    m = $signed(f[(2 * pr) * W + 2 * pc]);
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        v = $signed(f[(2 * pr + dr) * W + 2 * pc + dc]);
        if (v > m) m = v;
      end
    end
    return m[DW-1:0];
  endfunction

  // Queue results for every window whose last pixel lies within the first npx pixels sent
  task automatic expect_px(input frame_t f, input int npx);
    int pr;
    int pc;
    for (int k = 0; k < NOUT; k++) begin
      pr = k / (W / 2);
      pc = k % (W / 2);
      if ((2 * pr + 1) * W + 2 * pc + 1 < npx) begin
        exp_q.push_back({(k == NOUT - 1), pool_at(f, pr, pc)});
      end
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic sof);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        fail_now("accept_timeout", "beat never accepted");
        break;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input bit sof_first, input bit gaps,
                            input bit chk_lit, input lit_t lit);
    int k;
    for (int i = 0; i < NPX; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(f[i], sof_first && (i == 0));
      if (chk_lit && ((i / W) % 2 == 1) && ((i % W) % 2 == 1)) begin
        k = ((i / W) / 2) * (W / 2) + (i % W) / 2;
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, lit[k]);
        chk("lat_last", out_last, (k == NOUT - 1));
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail_now("drain_timeout", "results still outstanding");
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < NPX; i++) f[i] = DW'($urandom);
    return f;
  endfunction

  // Downstream ready pattern: 0 = always ready, 1 = random, 2 = driven by the test
  always @(posedge clk) begin
    #2;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Output scoreboard and stall-stability checks, sampled mid-cycle
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, (!out_valid || out_ready));
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("out_extra", $sformatf("got %0h want none", out_data));
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[DW-1:0]);
          chk("out_last", out_last, e[DW]);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    frame_t fa, fb, fs, fc, fd, fe, fr;
    lit_t   la, lb, ls, lnone;
    int     n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    lnone     = '{default: '0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < NPX; i++) begin
      fa[i] = DW'(i + 1);
      fb[i] = DW'(i + 2);
    end
    la = '{16'd6, 16'd8, 16'd14, 16'd16};
    lb = '{16'd7, 16'd9, 16'd15, 16'd17};

    // Basic pooling followed immediately by a +1 frame
    expect_px(fa, NPX);
    expect_px(fb, NPX);
    send_frame(fa, 1'b1, 1'b0, 1'b1, la);
    send_frame(fb, 1'b1, 1'b0, 1'b1, lb);
    drain();

    // Signed compare windows
    fs = '{16'hFFFD, 16'hFFFF, 16'h8000, 16'h8000,
           16'hFFF9, 16'h8000, 16'h8000, 16'h8000,
           16'h0064, 16'hFF38, 16'h0000, 16'h0000,
           16'hFFFB, 16'h0007, 16'hFFFF, 16'h8001};
    ls = '{16'hFFFF, 16'h8000, 16'h0064, 16'h0000};
    expect_px(fs, NPX);
    send_frame(fs, 1'b1, 1'b0, 1'b1, ls);
    drain();

    // Backpressure on the first result of a frame
    ready_mode = 2;
    out_ready  = 1'b1;
    expect_px(fa, NPX);
    fork
      send_frame(fa, 1'b1, 1'b0, 1'b0, lnone);
      begin
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 100);
        if (!out_valid) fail_now("bp_timeout", "no result appeared");
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #2;
          chk("bp_in_ready", in_ready, 0);
          chk("bp_valid", out_valid, 1);
          chk("bp_data", out_data, 16'd6);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    ready_mode = 0;
    drain();

    // Start-of-frame resync after a six-pixel fragment
    fc = rand_frame();
    fr = rand_frame();
    expect_px(fr, 6);
    expect_px(fc, NPX);
    for (int i = 0; i < 6; i++) send_beat(fr[i], 1'b0);
    send_frame(fc, 1'b1, 1'b0, 1'b0, lnone);
    drain();

    // Reset while a row-3 result is pending, then a frame without sof
    ready_mode = 2;
    out_ready  = 1'b1;
    fd = rand_frame();
    expect_px(fd, 13);
    for (int i = 0; i < 14; i++) send_beat(fd[i], (i == 0));
    chk("pre_rst_valid", out_valid, 1);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    fe = rand_frame();
    expect_px(fe, NPX);
    send_frame(fe, 1'b0, 1'b0, 1'b0, lnone);
    ready_mode = 0;
    drain();

    // Random frames, random input gaps, random downstream stalls
    ready_mode = 1;
    for (int f = 0; f < 8; f++) begin
      fr = rand_frame();
      expect_px(fr, NPX);
      send_frame(fr, 1'($urandom_range(0, 1)), 1'b1, 1'b0, lnone);
    end
    ready_mode = 0;
    drain();
    chk("queue_empty", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
